// File: rtl/rgb_frame_monitor.sv
// Pixel-stream monitor that tracks the x/y position of accepted RGB pixels and flags framing errors.
// Optional per-frame checksum is built when RGB_FRAME_MONITOR_CHECKSUM_EN is defined.
module rgb_frame_monitor #(
    parameter int unsigned H_ACTIVE   = 1920,
    parameter int unsigned V_ACTIVE   = 1080,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned FCNT_WIDTH = 16,
    localparam int unsigned XW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1,
    localparam int unsigned YW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1
) (
    input  logic                  pixclk,
    input  logic                  reset,
    input  logic                  iValid,
    input  logic                  iSof,
    input  logic                  iEol,
    input  logic [DATA_WIDTH-1:0] iRed,
    input  logic [DATA_WIDTH-1:0] iGreen,
    input  logic [DATA_WIDTH-1:0] iBlue,
    input  logic                  clear_err,
    output logic [XW-1:0]         x_coord,
    output logic [YW-1:0]         y_coord,
    output logic [1:0]            state,
    output logic                  frame_done,
    output logic [FCNT_WIDTH-1:0] frame_count,
    output logic [31:0]           checksum,
    output logic                  err_short_line,
    output logic                  err_long_line,
    output logic                  err_early_sof,
    output logic                  err_extra_pixel
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    localparam logic [XW-1:0] X_LAST = XW'(H_ACTIVE - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(V_ACTIVE - 1);

    state_t                  state_q;
    state_t                  state_d;
    logic [XW-1:0]           x_d;
    logic [YW-1:0]           y_d;
    logic                    done_d;
    logic [FCNT_WIDTH-1:0]   fcnt_d;
    logic                    short_d;
    logic                    long_d;
    logic                    sof_err_d;
    logic                    extra_d;

    logic                    accept_c;
    logic                    extra_c;
    logic                    early_sof_c;
    logic [XW-1:0]           pos_x_c;
    logic [YW-1:0]           pos_y_c;
    logic                    at_last_x_c;
    logic                    line_end_c;
    logic                    short_c;
    logic                    long_c;
    logic                    complete_c;

    // Classify the sampled pixel; a SOF pixel is evaluated at (0,0)
    always_comb begin
        accept_c    = iValid && (iSof || (state_q == ST_ACTIVE));
        extra_c     = iValid && !iSof && (state_q == ST_DONE);
        early_sof_c = iValid && iSof && (state_q == ST_ACTIVE);
        pos_x_c     = iSof ? '0 : x_coord;
        pos_y_c     = iSof ? '0 : y_coord;
        at_last_x_c = (pos_x_c == X_LAST);
        line_end_c  = accept_c && (iEol || at_last_x_c);
        short_c     = accept_c && iEol && !at_last_x_c;
        long_c      = accept_c && !iEol && at_last_x_c;
        complete_c  = line_end_c && (pos_y_c == Y_LAST);
    end

    // State register
    always_ff @(posedge pixclk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (complete_c) begin
            state_d = ST_DONE;
        end else if (accept_c) begin
            state_d = ST_ACTIVE;
        end
    end

    // Next values of coordinates, counters and sticky flags
    always_comb begin
        x_d       = x_coord;
        y_d       = y_coord;
        done_d    = 1'b0;
        fcnt_d    = frame_count;
        short_d   = short_c     | (err_short_line  & ~clear_err);
        long_d    = long_c      | (err_long_line   & ~clear_err);
        sof_err_d = early_sof_c | (err_early_sof   & ~clear_err);
        extra_d   = extra_c     | (err_extra_pixel & ~clear_err);
        if (accept_c) begin
            if (line_end_c) begin
                x_d = '0;
                y_d = complete_c ? '0 : (pos_y_c + YW'(1));
            end else begin
                x_d = pos_x_c + XW'(1);
                y_d = pos_y_c;
            end
        end
        if (complete_c) begin
            done_d = 1'b1;
            fcnt_d = frame_count + FCNT_WIDTH'(1);
        end
    end

    always_ff @(posedge pixclk or negedge reset) begin
        if (!reset) begin
            x_coord         <= '0;
            y_coord         <= '0;
            frame_done      <= 1'b0;
            frame_count     <= '0;
            err_short_line  <= 1'b0;
            err_long_line   <= 1'b0;
            err_early_sof   <= 1'b0;
            err_extra_pixel <= 1'b0;
        end else begin
            x_coord         <= x_d;
            y_coord         <= y_d;
            frame_done      <= done_d;
            frame_count     <= fcnt_d;
            err_short_line  <= short_d;
            err_long_line   <= long_d;
            err_early_sof   <= sof_err_d;
            err_extra_pixel <= extra_d;
        end
    end

    assign state = state_q;

`ifdef RGB_FRAME_MONITOR_CHECKSUM_EN
    logic [31:0] pix_c;
    logic [31:0] acc_q;
    logic [31:0] acc_d;
    logic [31:0] sum_d;

    // Running sum restarts on every accepted SOF; total latches on completion
    always_comb begin
        pix_c = 32'({iRed, iGreen, iBlue});
        acc_d = acc_q;
        sum_d = checksum;
        if (accept_c) begin
            acc_d = iSof ? pix_c : (acc_q + pix_c);
        end
        if (complete_c) begin
            sum_d = acc_d;
        end
    end

    always_ff @(posedge pixclk or negedge reset) begin
        if (!reset) begin
            acc_q    <= '0;
            checksum <= '0;
        end else begin
            acc_q    <= acc_d;
            checksum <= sum_d;
        end
    end
`else
    logic unused_pixel_data;
    assign unused_pixel_data = ^{iRed, iGreen, iBlue};
    assign checksum          = '0;
`endif

endmodule

// File: tb/tb_rgb_frame_monitor.sv
// Directed/random bench for rgb_frame_monitor at 4x3 resolution with a behavioural reference model.
module tb_rgb_frame_monitor;

    localparam int H = 4;
    localparam int V = 3;

    logic        pixclk = 1'b0;
    logic        reset;
    logic        iValid, iSof, iEol, clear_err;
    logic [7:0]  iRed, iGreen, iBlue;
    logic [1:0]  x_coord;
    logic [1:0]  y_coord;
    logic [1:0]  state;
    logic        frame_done;
    logic [15:0] frame_count;
    logic [31:0] checksum;
    logic        err_short_line, err_long_line, err_early_sof, err_extra_pixel;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: frame position, counters and flags as plain integers
    int          m_state, m_x, m_y;
    logic [15:0] m_fc;
    logic [31:0] m_acc, m_ck;
    bit          m_done, m_es, m_el, m_eso, m_ex;
    bit          gap_en, use_fixed;

    always #5 pixclk = ~pixclk;

    rgb_frame_monitor #(
        .H_ACTIVE(H), .V_ACTIVE(V), .DATA_WIDTH(8), .FCNT_WIDTH(16)
    ) dut (
        .pixclk(pixclk), .reset(reset), .iValid(iValid), .iSof(iSof), .iEol(iEol),
        .iRed(iRed), .iGreen(iGreen), .iBlue(iBlue), .clear_err(clear_err),
        .x_coord(x_coord), .y_coord(y_coord), .state(state), .frame_done(frame_done),
        .frame_count(frame_count), .checksum(checksum),
        .err_short_line(err_short_line), .err_long_line(err_long_line),
        .err_early_sof(err_early_sof), .err_extra_pixel(err_extra_pixel)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [31:0] exp_ck;
`ifdef RGB_FRAME_MONITOR_CHECKSUM_EN
        exp_ck = m_ck;
`else
        exp_ck = 32'd0;
`endif
        chk($sformatf("%s.state", tag), state, m_state);
        chk($sformatf("%s.x", tag), x_coord, m_x);
        chk($sformatf("%s.y", tag), y_coord, m_y);
        chk($sformatf("%s.done", tag), frame_done, m_done);
        chk($sformatf("%s.fcnt", tag), frame_count, m_fc);
        chk($sformatf("%s.cksum", tag), checksum, exp_ck);
        chk($sformatf("%s.e_short", tag), err_short_line, m_es);
        chk($sformatf("%s.e_long", tag), err_long_line, m_el);
        chk($sformatf("%s.e_sof", tag), err_early_sof, m_eso);
        chk($sformatf("%s.e_extra", tag), err_extra_pixel, m_ex);
    endtask

    task automatic model_reset();
        m_state = 0; m_x = 0; m_y = 0; m_fc = '0; m_acc = '0; m_ck = '0;
        m_done = 0; m_es = 0; m_el = 0; m_eso = 0; m_ex = 0;
    endtask

    task automatic model_step(input bit v, input bit sof, input bit eol, input bit clr,
                              input logic [23:0] rgb);
        bit acc_ok = 0;
        bit es = 0, el = 0, eso = 0, ex = 0;
        m_done = 0;
        if (v) begin
            if (sof) begin
                eso = (m_state == 1);
                m_state = 1; m_x = 0; m_y = 0;
                m_acc = 32'(rgb);
                acc_ok = 1;
            end else if (m_state == 1) begin
                m_acc = m_acc + 32'(rgb);
                acc_ok = 1;
            end else if (m_state == 2) begin
                ex = 1;
            end
            if (acc_ok) begin
                if (eol || m_x == H - 1) begin
                    es = eol && (m_x < H - 1);
                    el = !eol && (m_x == H - 1);
                    m_x = 0;
                    if (m_y < V - 1) begin
                        m_y++;
                    end else begin
                        m_y = 0; m_done = 1; m_fc = m_fc + 16'd1; m_ck = m_acc; m_state = 2;
                    end
                end else begin
                    m_x++;
                end
            end
        end
        m_es  = es  | (m_es  & !clr);
        m_el  = el  | (m_el  & !clr);
        m_eso = eso | (m_eso & !clr);
        m_ex  = ex  | (m_ex  & !clr);
    endtask

    task automatic step(input bit v, input bit sof, input bit eol, input bit clr,
                        input logic [23:0] rgb, input string tag);
        iValid = v; iSof = sof; iEol = eol; clear_err = clr;
        {iRed, iGreen, iBlue} = rgb;
        @(posedge pixclk);
        #1;
        model_step(v, sof, eol, clr, rgb);
        check_all(tag);
        iValid = 0; iSof = 0; iEol = 0; clear_err = 0;
    endtask

    task automatic pix(input bit sof, input bit eol, input string tag);
        logic [23:0] rgb;
        if (gap_en) begin
            repeat ($urandom_range(0, 2))
                step(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, 24'($urandom), "gap");
        end
        rgb = use_fixed ? 24'h010203 : 24'($urandom);
        step(1, sof, eol, 0, rgb, tag);
    endtask

    task automatic do_reset(input string tag);
        reset = 0;
        #2;
        model_reset();
        check_all(tag);
        @(negedge pixclk);
        reset = 1;
        @(posedge pixclk);
        #1;
    endtask

    initial begin
        reset = 1; iValid = 0; iSof = 0; iEol = 0; clear_err = 0;
        iRed = '0; iGreen = '0; iBlue = '0;
        gap_en = 0; use_fixed = 1;
        model_reset();
        @(posedge pixclk);
        #1;
        do_reset("reset");

        // Nominal frame with a constant pixel value
        for (int i = 0; i < 12; i++) pix(i == 0, (i % 4) == 3, "nominal");
        chk("nominal.fcnt_abs", frame_count, 16'd1);
`ifdef RGB_FRAME_MONITOR_CHECKSUM_EN
        chk("nominal.cksum_abs", checksum, 32'h000C1824);
`endif
        use_fixed = 0;

        // Short line 0, then two complete lines; back-to-back with the previous frame
        for (int i = 0; i < 3; i++) pix(i == 0, i == 2, "short");
        for (int i = 0; i < 8; i++) pix(0, (i % 4) == 3, "short");
        step(0, 0, 0, 1, 24'd0, "short.clr");

        // Missing EOL on line 1 forces a wrap; then a non-SOF pixel after completion
        for (int i = 0; i < 12; i++) pix(i == 0, ((i % 4) == 3) && (i != 7), "long");
        step(1, 0, 0, 1, 24'($urandom), "extra_with_clr");
        step(0, 0, 0, 1, 24'd0, "extra.clr");

        // Early SOF at (2,1) restarts the frame
        for (int i = 0; i < 6; i++) pix(i == 0, (i % 4) == 3, "pre_sof");
        pix(1, 0, "early_sof");
        for (int k = 1; k < 12; k++) pix(0, (k % 4) == 3, "post_sof");
        step(0, 0, 0, 1, 24'd0, "sof.clr");

        // SOF and EOL on the same pixel: short line at x=0
        pix(1, 1, "sof_eol");
        for (int i = 0; i < 8; i++) pix(0, (i % 4) == 3, "sof_eol");
        step(0, 0, 0, 1, 24'd0, "sof_eol.clr");

        // Two frames with random stalls, then a partial third frame cut by reset
        gap_en = 1;
        for (int f = 0; f < 2; f++)
            for (int i = 0; i < 12; i++) pix(i == 0, (i % 4) == 3, "stall");
        for (int i = 0; i < 9; i++) pix(i == 0, (i % 4) == 3, "partial");
        gap_en = 0;
        do_reset("mid_reset");
        step(1, 0, 0, 0, 24'($urandom), "stray");
        step(1, 0, 1, 0, 24'($urandom), "stray_eol");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
